d_flip_flop: RTL and testbench

//   Parameterised edge-triggered data register: the 32-bit pipeline/state register of the RISC-V core
//   (PC register, inter-stage latches). Captures d on every rising clock edge, no enable.

---
 rtl/d_flip_flop_pkg.sv | 5 +
 rtl/d_flip_flop_if.sv | 7 +
 rtl/d_flip_flop_stage.sv | 13 +
 rtl/d_flip_flop.sv | 31 +++
 tb/tb_d_flip_flop.sv | 96 +++++++++
 5 files changed

// File: rtl/d_flip_flop_pkg.sv
// d_flip_flop_pkg: shared core-wide constants for the pipeline/state registers
package d_flip_flop_pkg;
   localparam int XLEN = 32;
   typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/d_flip_flop_if.sv
// d_flip_flop_if: data-in / data-out bundle of a register or delay line
interface d_flip_flop_if import d_flip_flop_pkg::*; #(parameter int WIDTH = XLEN);
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   modport master(output d, input q);
   modport slave(input d, output q);
endinterface

// File: rtl/d_flip_flop_stage.sv
// d_flip_flop_stage: one WIDTH-bit register with synchronous active-high reset
module d_flip_flop_stage import d_flip_flop_pkg::*; #(
   parameter int WIDTH = XLEN,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   // capture d on every rising edge; reset takes priority and ignores d
   always_ff @(posedge clk) q <= rst ? RESET_VALUE : d;
endmodule

// File: rtl/d_flip_flop.sv
// d_flip_flop: edge-triggered data register, optionally a fixed-latency delay line of STAGES flops
module d_flip_flop import d_flip_flop_pkg::*; #(
   parameter int WIDTH = XLEN,
   parameter int STAGES = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input logic        clk,
   input logic        rst,
   d_flip_flop_if.slave bus
);
   if (WIDTH < 1 || STAGES < 1) begin : g_bad_param
      $error("d_flip_flop: WIDTH and STAGES must both be >= 1");
   end
   logic [WIDTH-1:0] chain [STAGES+1];
   assign chain[0] = bus.d;
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      d_flip_flop_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stage (
         .clk(clk),
         .rst(rst),
         .d  (chain[i]),
         .q  (chain[i+1])
      );
   end
   assign bus.q = chain[STAGES];
`ifndef SYNTHESIS
   logic seen_rst;
   // remember that a reset edge has happened so q is defined from then on
   always_ff @(posedge clk) if (rst) seen_rst <= 1'b1;
   a_q_known: assert property (@(posedge clk) seen_rst === 1'b1 |-> !$isunknown(bus.q));
`endif
endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: random and directed checks of a 32-bit single-stage register and an 8-bit 3-stage delay line
module tb_d_flip_flop;
   logic clk;
   logic rst;
   int vectors = 0;
   int miscompares = 0;
   d_flip_flop_if #(.WIDTH(32)) bus32();
   d_flip_flop_if #(.WIDTH(8)) bus8();
   d_flip_flop #(.WIDTH(32), .STAGES(1)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   d_flip_flop #(.WIDTH(8), .STAGES(3)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   logic [31:0] m32[$];
   logic [7:0] m8[$];
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   // reference: q after an edge is the d captured STAGES edges ago, or 0 if a reset edge intervened
   always @(posedge clk) begin
      if (rst) begin
         m32 = '{32'h0};
         m8 = '{8'h0, 8'h0, 8'h0};
      end else begin
         m32.push_back(bus32.d);
         void'(m32.pop_front());
         m8.push_back(bus8.d);
         void'(m8.pop_front());
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic cyc(input logic r, input logic [31:0] dv, input logic [7:0] d8v);
      rst = r;
      bus32.d = dv;
      bus8.d = d8v;
      @(negedge clk);
      check("q32", bus32.q, m32[0]);
      check("q8", {24'h0, bus8.q}, {24'h0, m8[0]});
   endtask
   initial begin
      m32 = '{32'hx};
      m8 = '{8'hx, 8'hx, 8'hx};
      rst = 1'b1;
      bus32.d = '0;
      bus8.d = '0;
      @(negedge clk);
      check("reset32", bus32.q, 32'h0);
      check("reset8", {24'h0, bus8.q}, 32'h0);
      cyc(1'b0, 32'h12345678, 8'h00);
      check("first", bus32.q, 32'h12345678);
      cyc(1'b0, 32'h87654321, 8'h00);
      check("second", bus32.q, 32'h87654321);
      rst = 1'b1;
      #2;
      check("rst_midcycle", bus32.q, 32'h87654321);
      @(negedge clk);
      check("rst_edge", bus32.q, 32'h0);
      cyc(1'b0, 32'hDEADBEEF, 8'h00);
      check("deadbeef", bus32.q, 32'hDEADBEEF);
      cyc(1'b0, 32'hDEADBEEF, 8'h00);
      cyc(1'b0, 32'hDEADBEEF, 8'h00);
      check("hold", bus32.q, 32'hDEADBEEF);
      bus32.d = 32'hAAAAAAAA;
      #2;
      bus32.d = 32'h55555555;
      @(negedge clk);
      check("toggle", bus32.q, 32'h55555555);
      cyc(1'b0, 32'h0, 8'h01);
      cyc(1'b0, 32'h0, 8'h02);
      check("lat_pending", {24'h0, bus8.q}, 32'h0);
      cyc(1'b0, 32'h0, 8'h03);
      check("lat3_01", {24'h0, bus8.q}, 32'h01);
      cyc(1'b0, 32'h0, 8'h04);
      check("lat3_02", {24'h0, bus8.q}, 32'h02);
      cyc(1'b0, 32'h0, 8'h05);
      check("lat3_03", {24'h0, bus8.q}, 32'h03);
      rst = 1'b1;
      #2;
      check("rst8_midcycle", {24'h0, bus8.q}, 32'h03);
      @(negedge clk);
      check("flush", {24'h0, bus8.q}, 32'h0);
      cyc(1'b0, 32'h0, 8'h77);
      cyc(1'b0, 32'h0, 8'h88);
      check("flushed_1", {24'h0, bus8.q}, 32'h0);
      cyc(1'b0, 32'h0, 8'h99);
      check("post_rst", {24'h0, bus8.q}, 32'h77);
      for (int n = 0; n < 300; n++)
         cyc($urandom_range(15) == 0, $urandom, 8'($urandom));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
